// File: rtl/d_sync_debounce.sv
// d_sync_debounce
//   Input conditioning stage in front of a d_ff storage element. A raw
//   asynchronous level is synchronised through SYNC_STAGES flops, debounced
//   with a stability counter, and presented as a registered level Q/Qbar
//   with one-cycle RISE/FALL pulses on every accepted change.
//
//   Optional feature macro: DEBOUNCE_EVT_CNT_EN
//     defined   -> EVT_CNT output and a CNT_W-bit wrapping rising-event counter
//     undefined -> no EVT_CNT port, CNT_W only feeds the parameter checker
//
//   Reset RST_N is asynchronous and active-low; every register has a reset
//   value, so nothing downstream ever sees X.

module d_sync_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             D_IN,
    output logic             Q,
    output logic             Qbar,
    output logic             RISE,
    output logic             FALL
`ifdef DEBOUNCE_EVT_CNT_EN
    ,
    output logic [CNT_W-1:0] EVT_CNT
`endif
);

    // One extra bit over clog2 so DB_CYCLES=1 still yields a legal 1-bit counter.
    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_sync_s;

    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_nxt_s;
    logic                   q_r;
    logic                   q_nxt_s;
    logic                   rise_r;
    logic                   rise_nxt_s;
    logic                   fall_r;
    logic                   fall_nxt_s;

    // Synchroniser chain: bit 0 samples the raw pin, each stage follows the previous.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], D_IN};
        end
    end

    assign s_sync_s = sync_r[SYNC_STAGES-1];

    // Debounce decision: count cycles of disagreement, accept the new level
    // only once it has persisted DB_CYCLES edges; any agreement restarts.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        q_nxt_s    = q_r;
        rise_nxt_s = 1'b0;
        fall_nxt_s = 1'b0;
        if (s_sync_s == q_r) begin
            cnt_nxt_s = '0;
        end else if (cnt_r == CNT_LAST) begin
            q_nxt_s    = s_sync_s;
            cnt_nxt_s  = '0;
            rise_nxt_s = s_sync_s;
            fall_nxt_s = ~s_sync_s;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Debounce state, debounced level and edge pulses registered together so
    // RISE/FALL assert on exactly the edge that Q changes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r  <= '0;
            q_r    <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            q_r    <= q_nxt_s;
            rise_r <= rise_nxt_s;
            fall_r <= fall_nxt_s;
        end
    end

    assign Q    = q_r;
    assign Qbar = ~q_r;
    assign RISE = rise_r;
    assign FALL = fall_r;

`ifdef DEBOUNCE_EVT_CNT_EN
    logic [CNT_W-1:0] evt_cnt_r;

    // Rising-event counter: one increment per RISE cycle, free wrap at 2^CNT_W.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            evt_cnt_r <= '0;
        end else begin
            evt_cnt_r <= evt_cnt_r + CNT_W'(rise_r);
        end
    end

    assign EVT_CNT = evt_cnt_r;
`endif

    d_sync_debounce_chk #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES),
        .CNT_W       (CNT_W)
    ) u_chk (
        .clk   (CLK),
        .rst_n (RST_N),
        .q     (q_r),
        .qbar  (Qbar),
        .rise  (rise_r),
        .fall  (fall_r)
    );

endmodule

// d_sync_debounce_chk
//   Property checker for d_sync_debounce: legal parameters, complementary
//   outputs and well-formed edge pulses. Holds no design state.
module d_sync_debounce_chk #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 8
) (
    input logic clk,
    input logic rst_n,
    input logic q,
    input logic qbar,
    input logic rise,
    input logic fall
);

    a_param_legal: assert property (@(posedge clk)
        (SYNC_STAGES >= 2) && (SYNC_STAGES <= 4) && (DB_CYCLES >= 1) && (CNT_W >= 1));

    a_qbar_compl: assert property (@(posedge clk) qbar == ~q);

    a_edge_excl: assert property (@(posedge clk) disable iff (!rst_n) !(rise && fall));

    a_rise_one_cycle: assert property (@(posedge clk) disable iff (!rst_n) rise |=> !rise);

    a_fall_one_cycle: assert property (@(posedge clk) disable iff (!rst_n) fall |=> !fall);

    a_rise_sets_q: assert property (@(posedge clk) disable iff (!rst_n) rise |-> q);

    a_fall_clears_q: assert property (@(posedge clk) disable iff (!rst_n) fall |-> !q);

endmodule

// File: tb/tb_d_sync_debounce.sv
// tb_d_sync_debounce
//   Directed bench for d_sync_debounce with SYNC_STAGES=2, DB_CYCLES=4 and a
//   10 ns clock. Expected values are hand-derived: a D_IN change set up 2 ns
//   before edge 1 reaches Q at edge 6. Outputs are sampled 1 ns after posedge.

module tb_d_sync_debounce;

    logic       CLK;
    logic       RST_N;
    logic       D_IN;
    logic       Q;
    logic       Qbar;
    logic       RISE;
    logic       FALL;
`ifdef DEBOUNCE_EVT_CNT_EN
    logic [1:0] EVT_CNT;
`endif

    int n_checks;
    int n_fail;

    d_sync_debounce #(
        .SYNC_STAGES (2),
        .DB_CYCLES   (4),
        .CNT_W       (2)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .D_IN    (D_IN),
        .Q       (Q),
        .Qbar    (Qbar),
        .RISE    (RISE),
        .FALL    (FALL)
`ifdef DEBOUNCE_EVT_CNT_EN
        ,
        .EVT_CNT (EVT_CNT)
`endif
    );

    // 10 ns clock, posedges at 5, 15, 25 ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Check all level outputs at once against the expected Q and pulses.
    task automatic chk_outs(input string tag, input logic eq, input logic er, input logic ef);
        chk({tag, ".Q"},    {31'd0, Q},    {31'd0, eq});
        chk({tag, ".Qbar"}, {31'd0, Qbar}, {31'd0, ~eq});
        chk({tag, ".RISE"}, {31'd0, RISE}, {31'd0, er});
        chk({tag, ".FALL"}, {31'd0, FALL}, {31'd0, ef});
    endtask

    // Apply D_IN=d 2 ns before edge 1 and hold; Q flips at edge 6 from ~d to d.
    task automatic drive_level(input string tag, input logic d, input int n_edges);
        logic old_q;
        old_q = ~d;
        @(posedge CLK);
        #8;
        D_IN = d;
        for (int e = 1; e <= n_edges; e++) begin
            @(posedge CLK);
            #1;
            chk_outs($sformatf("%s.e%0d", tag, e),
                     (e >= 6) ? d : old_q,
                     (e == 6) && d,
                     (e == 6) && !d);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST_N    = 1'b0;
        D_IN     = 1'b0;

        // Reset applied from time 0, before any clock edge.
        #1;
        chk_outs("rst0", 1'b0, 1'b0, 1'b0);
`ifdef DEBOUNCE_EVT_CNT_EN
        chk("rst0.EVT_CNT", {30'd0, EVT_CNT}, 32'd0);
`endif
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // Clean rise: Q=1 and RISE at edge 6, RISE gone at edge 7.
        drive_level("rise", 1'b1, 7);

        // Clean fall: Q=0 and FALL at edge 6 only.
        drive_level("fall", 1'b0, 7);

        // Glitch: D_IN high for 3 cycles only; Q and RISE must stay low.
        @(posedge CLK);
        #8;
        D_IN = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge CLK);
            #1;
            chk_outs($sformatf("glitch.e%0d", e), 1'b0, 1'b0, 1'b0);
        end
        #7;
        D_IN = 1'b0;
        for (int e = 4; e <= 10; e++) begin
            @(posedge CLK);
            #1;
            chk_outs($sformatf("glitch.e%0d", e), 1'b0, 1'b0, 1'b0);
        end

        // After the glitch the counter must start from 0: full latency again.
        drive_level("post_glitch", 1'b1, 7);
        drive_level("fall2", 1'b0, 7);

        // Reset mid-debounce: D_IN high for 4 edges, then RST_N low one cycle.
        @(posedge CLK);
        #8;
        D_IN = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge CLK);
            #1;
            chk_outs($sformatf("middb.e%0d", e), 1'b0, 1'b0, 1'b0);
        end
        #2;
        RST_N = 1'b0;
        #1;
        chk_outs("middb.in_rst", 1'b0, 1'b0, 1'b0);
        #9;
        RST_N = 1'b1;
        for (int r = 1; r <= 6; r++) begin
            @(posedge CLK);
            #1;
            chk_outs($sformatf("middb.r%0d", r), (r >= 6), (r == 6), 1'b0);
        end

        // Asynchronous reset between edges while Q=1 and RISE=1.
        #2;
        RST_N = 1'b0;
        #1;
        chk_outs("async_rst", 1'b0, 1'b0, 1'b0);
`ifdef DEBOUNCE_EVT_CNT_EN
        chk("async_rst.EVT_CNT", {30'd0, EVT_CNT}, 32'd0);
`endif
        D_IN = 1'b0;
        @(posedge CLK);
        #1;
        chk_outs("async_rst.edge", 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;

`ifdef DEBOUNCE_EVT_CNT_EN
        // Five clean pulses of 8 cycles each: 2-bit counter reads 1,2,3,0,1.
        begin
            logic [1:0] exp_cnt [5];
            exp_cnt[0] = 2'd1;
            exp_cnt[1] = 2'd2;
            exp_cnt[2] = 2'd3;
            exp_cnt[3] = 2'd0;
            exp_cnt[4] = 2'd1;
            for (int p = 0; p < 5; p++) begin
                drive_level($sformatf("evt%0d.hi", p), 1'b1, 8);
                // drive_level ends at edge 8; EVT_CNT updated at edge 7.
                chk($sformatf("evt%0d.EVT_CNT", p), {30'd0, EVT_CNT}, {30'd0, exp_cnt[p]});
                drive_level($sformatf("evt%0d.lo", p), 1'b0, 8);
                chk($sformatf("evt%0d.EVT_CNT_lo", p), {30'd0, EVT_CNT}, {30'd0, exp_cnt[p]});
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/d_sync_debounce.md
Name: d_sync_debounce

Overview:
- Input conditioning stage that sits directly upstream of the d_ff storage element.
- Takes a raw asynchronous level (switch, pin or external strobe) and synchronises it into the CLK domain through an N-stage flop chain.
- Debounces it with a stability counter and presents a clean registered level on Q/Qbar, plus one-cycle RISE/FALL edge pulses for downstream sequential logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
- DB_CYCLES, 4, consecutive CLK cycles the synchronised input must differ from Q before Q updates; legal range >=1.
- CNT_W, 8, width of EVT_CNT; used only with DEBOUNCE_EVT_CNT_EN.

Ports:
- CLK  input  1  single clock; all state updates on posedge.
- RST_N  input  1  asynchronous, active-low reset.
- D_IN  input  1  raw asynchronous input level.
- Q  output  1  debounced, registered level.
- Qbar  output  1  combinational ~Q.
- RISE  output  1  one-cycle pulse on Q 0->1.
- FALL  output  1  one-cycle pulse on Q 1->0.
- EVT_CNT  output  CNT_W  rising-event count; present only with DEBOUNCE_EVT_CNT_EN.

Behaviour:
- Clock and reset: one clock (CLK); reset RST_N is asynchronous and active-low.
  - Assertion clears all state immediately, with no clock edge required.
  - Deassertion is sampled by CLK.
- Reset values:
  - sync chain all 0, debounce counter 0.
  - Q=0, Qbar=1, RISE=0, FALL=0, EVT_CNT=0.
- Synchroniser:
  - s[0] <= D_IN, s[k] <= s[k-1].
  - s_sync = s[SYNC_STAGES-1].
  - A D_IN change meeting setup before edge 1 appears on s_sync after edge SYNC_STAGES.
- Debounce counter:
  - Width clog2(DB_CYCLES)+1, internal.
  - At each edge, if s_sync==Q: counter <= 0.
  - Else if counter==DB_CYCLES-1: Q <= s_sync, counter <= 0.
  - Else: counter <= counter+1.
- Latency: Q updates at edge SYNC_STAGES+DB_CYCLES after the D_IN change. Defaults: edge 6.
- Glitch rejection:
  - Any s_sync excursion shorter than DB_CYCLES cycles clears the counter.
  - Q does not change and no pulse is produced.
- Edge pulses:
  - RISE/FALL are registered and assert on the same edge that Q updates.
  - Each stays high exactly one cycle, then deasserts at the next edge.
  - RISE and FALL are never simultaneously high.
- DB_CYCLES=1: Q updates on the first edge at which s_sync!=Q.
- Reset mid-debounce:
  - Counter progress and sync contents are discarded.
  - After release, full latency applies from scratch.
- Qbar is always exactly ~Q, including during reset.
- No X propagation: every register has a reset value.

Optional Feature:
- Macro DEBOUNCE_EVT_CNT_EN.
- Defined:
  - EVT_CNT port and a CNT_W-bit counter exist.
  - The counter increments by 1 on every cycle RISE is high.
  - It wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
  - Reset to 0 by RST_N.
  - EVT_CNT updates one edge after RISE asserts.
- Undefined: EVT_CNT port and counter are absent; CNT_W is ignored; all other behaviour is identical.

Test Plan:
Conditions for all scenarios: 10 ns clock, SYNC_STAGES=2, DB_CYCLES=4; edges are numbered from the first edge after the stimulus.
1. RST_N=0 asserted between edges -> immediately Q=0, Qbar=1, RISE=0, FALL=0, EVT_CNT=0, with no CLK edge required.
2. Q=0, D_IN 0->1 applied 2 ns before edge 1 and held -> Q=0 through edge 5; Q=1, Qbar=0, RISE=1 after edge 6; RISE=0 after edge 7; FALL stays 0.
3. Q=0, D_IN high for 3 cycles then low -> Q stays 0, RISE never asserts, and the counter returns to 0.
4. Q=1, D_IN 1->0 held -> Q=0 after edge 6, FALL high for exactly one cycle, RISE stays 0.
5. Q=0, D_IN high for 4 cycles, then RST_N pulsed low for 1 cycle while D_IN stays high -> Q stays 0 through reset; Q=1 at the 6th edge after RST_N release.
6. DEBOUNCE_EVT_CNT_EN defined, CNT_W=2, five clean 0->1->0 pulses each held 8 cycles -> EVT_CNT reads 1, 2, 3, 0, 1 after successive RISE pulses.
